pkt_dispatch_ctrl: RTL and testbench

//  Sequencer between the RX packet parser and the node-state units (myNodeInfo, neighbour table, TX forwarder).

---
 rtl/eerrl_pkg.sv | 21 ++
 rtl/dispatch_timer.sv | 21 ++
 rtl/pkt_dispatch_ctrl.sv | 158 +++++++++++++++
 tb/tb_pkt_dispatch_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/eerrl_pkg.sv
// Shared definitions for the packet dispatch controller: packet type codes,
// field width and FSM state encoding.
package eerrl_pkg;
  localparam int WORD_WIDTH = 16;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CHE  = 3'b001;
  localparam logic [2:0] PKT_INV  = 3'b010;
  localparam logic [2:0] PKT_CHTS = 3'b100;
  localparam logic [2:0] PKT_DATA = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_MNI     = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_NT      = 3'd4,
    ST_NT_WAIT = 3'd5,
    ST_FWD     = 3'd6
  } state_e;
endpackage

// File: rtl/dispatch_timer.sv
// Loadable down-counter; counts to zero and holds there. Shared by the
// MNI settle window and the neighbour-table timeout.
module dispatch_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)              cnt_q <= '0;
    else if (load_i)        cnt_q <= value_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/pkt_dispatch_ctrl.sv
// Sequences one parsed packet through myNodeInfo, neighbour table and TX
// forwarder enables; drops no-work/unsupported packets and counts them.
module pkt_dispatch_ctrl
  import eerrl_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int NT_TIMEOUT = 15,
  parameter int DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [2:0]            pkt_type,
  input  logic [WORD_WIDTH-1:0] pkt_destID,
  input  logic [WORD_WIDTH-1:0] pkt_hops,
  input  logic [WORD_WIDTH-1:0] pkt_energy,
  input  logic [WORD_WIDTH-1:0] pkt_timeslot,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  role,
  input  logic                  nt_done,
  input  logic                  fwd_ready,
  output logic                  en_MNI,
  output logic                  en_NT,
  output logic                  fwd_req,
  output logic [2:0]            fPktType,
  output logic [WORD_WIDTH-1:0] destinationID,
  output logic [WORD_WIDTH-1:0] hops,
  output logic [WORD_WIDTH-1:0] energy,
  output logic [WORD_WIDTH-1:0] timeslot,
  output logic [DROP_W-1:0]     drop_cnt,
  output logic                  busy
);
  localparam int TMR_MAX = (SETTLE_CYC > NT_TIMEOUT) ? SETTLE_CYC : NT_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e                state_q, state_d;
  logic [2:0]            type_q;
  logic [WORD_WIDTH-1:0] dest_q, hops_q, energy_q, tslot_q;
  logic                  dst_me_q, dst_me_d;
  logic                  hb_lock_q, hb_lock_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic                  capture, drop_inc, fwd_go, dst_me_now;
  logic                  tmr_load, tmr_zero;
  logic [TMR_W-1:0]      tmr_val;

  dispatch_timer #(.CNT_W(TMR_W)) u_timer (
    .clk     (clk),
    .nrst    (nrst),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .zero_o  (tmr_zero)
  );

  assign dst_me_now = (dest_q == myNodeID);
  // After the NT step: HB forwards once until relocked, DATA only to us.
  assign fwd_go = ((type_q == PKT_HB) && !hb_lock_q) ||
                  ((type_q == PKT_DATA) && dst_me_q);

  always_comb begin
    state_d   = state_q;
    hb_lock_d = hb_lock_q;
    dst_me_d  = dst_me_q;
    capture   = 1'b0;
    drop_inc  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      ST_IDLE: if (pkt_valid) begin
        capture = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        dst_me_d = dst_me_now;
        state_d  = ST_IDLE;
        case (type_q)
          PKT_HB, PKT_CHE: state_d = ST_MNI;
          PKT_INV: if (role) state_d = ST_NT;
                   else      drop_inc = 1'b1;
          PKT_CHTS: if (dst_me_now) begin
                      state_d   = ST_MNI;
                      hb_lock_d = 1'b0;
                    end else drop_inc = 1'b1;
          PKT_DATA: begin
            state_d   = ST_NT;
            hb_lock_d = 1'b0;
          end
          default: drop_inc = 1'b1;
        endcase
      end
      ST_MNI: begin
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(SETTLE_CYC - 1);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: if (tmr_zero) state_d = (type_q == PKT_HB) ? ST_NT : ST_IDLE;
      ST_NT: begin
        if (nt_done) state_d = fwd_go ? ST_FWD : ST_IDLE;
        else begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(NT_TIMEOUT - 1);
          state_d  = ST_NT_WAIT;
        end
      end
      ST_NT_WAIT: begin
        if (nt_done) state_d = fwd_go ? ST_FWD : ST_IDLE;
        else if (tmr_zero) begin
          drop_inc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_FWD: if (fwd_ready) begin
        state_d = ST_IDLE;
        if (type_q == PKT_HB) hb_lock_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    drop_d = (drop_inc && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      hb_lock_q <= 1'b0;
      dst_me_q  <= 1'b0;
      drop_q    <= '0;
      type_q    <= 3'b111;
      dest_q    <= '0;
      hops_q    <= '0;
      energy_q  <= '0;
      tslot_q   <= '0;
    end else begin
      state_q   <= state_d;
      hb_lock_q <= hb_lock_d;
      dst_me_q  <= dst_me_d;
      drop_q    <= drop_d;
      if (capture) begin
        type_q   <= pkt_type;
        dest_q   <= pkt_destID;
        hops_q   <= pkt_hops;
        energy_q <= pkt_energy;
        tslot_q  <= pkt_timeslot;
      end
    end
  end

  assign pkt_ready     = (state_q == ST_IDLE);
  assign busy          = ~pkt_ready;
  assign en_MNI        = (state_q == ST_MNI);
  assign en_NT         = (state_q == ST_NT);
  assign fwd_req       = (state_q == ST_FWD);
  assign fPktType      = type_q;
  assign destinationID = dest_q;
  assign hops          = (fwd_req && !(&hops_q)) ? hops_q + 1'b1 : hops_q;
  assign energy        = energy_q;
  assign timeslot      = tslot_q;
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_pkt_dispatch_ctrl.sv
// Randomized bench for pkt_dispatch_ctrl with a per-packet reference model
// predicting enable counts, forward hops, busy duration and drop count.
module tb_pkt_dispatch_ctrl;
  import eerrl_pkg::*;

  localparam int          SETTLE = 2;
  localparam int          NTTO   = 15;
  localparam logic [15:0] MY     = 16'h000C;

  logic        clk = 1'b0, nrst = 1'b0;
  logic        pkt_valid = 1'b0, pkt_ready;
  logic [2:0]  pkt_type = '0, fPktType;
  logic [15:0] pkt_destID = '0, pkt_hops = '0, pkt_energy = '0, pkt_timeslot = '0;
  logic [15:0] myNodeID = MY;
  logic        role = 1'b0, nt_done = 1'b0, fwd_ready = 1'b0;
  logic        en_MNI, en_NT, fwd_req, busy;
  logic [15:0] destinationID, hops, energy, timeslot;
  logic [7:0]  drop_cnt;

  int vectors = 0, miscompares = 0;
  int m_drop  = 0;
  bit m_lock  = 1'b0;

  pkt_dispatch_ctrl #(.SETTLE_CYC(SETTLE), .NT_TIMEOUT(NTTO), .DROP_W(8)) dut (
    .clk(clk), .nrst(nrst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_type(pkt_type), .pkt_destID(pkt_destID), .pkt_hops(pkt_hops),
    .pkt_energy(pkt_energy), .pkt_timeslot(pkt_timeslot), .myNodeID(myNodeID),
    .role(role), .nt_done(nt_done), .fwd_ready(fwd_ready), .en_MNI(en_MNI),
    .en_NT(en_NT), .fwd_req(fwd_req), .fPktType(fPktType),
    .destinationID(destinationID), .hops(hops), .energy(energy),
    .timeslot(timeslot), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // nt_d: cycles from the en_NT cycle to nt_done (0 = same cycle, <0 = never).
  // fw_d: cycles fwd_ready lags the first fwd_req cycle.
  task automatic send(input logic [2:0] t, input logic [15:0] d, input logic [15:0] h,
                      input logic [15:0] e, input logic [15:0] ts, input logic r,
                      input int nt_d, input int fw_d);
    int mni_n = 0, nt_n = 0, fwd_n = 0, nt_at = -1, fwd_at = -1, lat = -1, exp_lat;
    logic [15:0] fhops = '0, exp_hops;
    bit e_mni = 0, e_nt = 0, e_fwd = 0, e_drop = 0, abort, dst_me;

    dst_me = (d == MY);
    case (t)
      PKT_HB:   begin e_mni = 1; e_nt = 1; e_fwd = !m_lock; end
      PKT_CHE:  e_mni = 1;
      PKT_INV:  if (r) e_nt = 1; else e_drop = 1;
      PKT_CHTS: if (dst_me) begin e_mni = 1; m_lock = 0; end else e_drop = 1;
      PKT_DATA: begin e_nt = 1; e_fwd = dst_me; m_lock = 0; end
      default:  e_drop = 1;
    endcase
    abort = e_nt && (nt_d < 0 || nt_d > NTTO);
    if (abort) begin e_fwd = 0; e_drop = 1; end
    if (e_fwd && t == PKT_HB) m_lock = 1;
    if (e_drop && m_drop < 255) m_drop++;
    exp_lat = 1 + (e_mni ? 1 + SETTLE : 0) + (e_nt ? 1 + (abort ? NTTO : nt_d) : 0)
                + (e_fwd ? fw_d + 1 : 0);
    exp_hops = (h == 16'hFFFF) ? h : h + 16'd1;

    role = r; pkt_type = t; pkt_destID = d; pkt_hops = h;
    pkt_energy = e; pkt_timeslot = ts; pkt_valid = 1'b1;
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    pkt_type = 3'($urandom); pkt_destID = 16'($urandom); pkt_hops = 16'($urandom);
    pkt_energy = 16'($urandom); pkt_timeslot = 16'($urandom);

    chk("ftype", 32'(fPktType), 32'(t));
    chk("dest", 32'(destinationID), 32'(d));
    chk("energy", 32'(energy), 32'(e));
    chk("tslot", 32'(timeslot), 32'(ts));
    for (int c = 1; c <= 100; c++) begin
      if (pkt_ready) begin lat = c - 1; break; end
      if (en_MNI) mni_n++;
      if (en_NT) begin nt_n++; nt_at = (nt_d >= 0) ? c + nt_d : -1; end
      if (fwd_req) begin
        if (fwd_n == 0) begin fhops = hops; fwd_at = c + fw_d; end
        fwd_n++;
      end
      nt_done   = (c == nt_at);
      fwd_ready = (c == fwd_at);
      @(posedge clk); #1;
    end
    nt_done = 1'b0; fwd_ready = 1'b0;

    chk("latency", 32'(lat), 32'(exp_lat));
    chk("en_MNI_cnt", 32'(mni_n), 32'(e_mni));
    chk("en_NT_cnt", 32'(nt_n), 32'(e_nt));
    chk("fwd_cycles", 32'(fwd_n), 32'(e_fwd ? fw_d + 1 : 0));
    if (e_fwd) chk("fwd_hops", 32'(fhops), 32'(exp_hops));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic reset_mid;
    role = 1'b0; pkt_type = PKT_CHE; pkt_destID = 16'd5; pkt_hops = 16'd9;
    pkt_energy = 16'h1234; pkt_timeslot = 16'd3; pkt_valid = 1'b1;
    @(posedge clk); #1; pkt_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("rst_ready", 32'(pkt_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'({en_MNI, en_NT, fwd_req}), 32'd0);
    chk("rst_ftype", 32'(fPktType), 32'h7);
    chk("rst_fields", 32'(destinationID | hops | energy | timeslot), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    m_drop = 0; m_lock = 1'b0;
    #3 nrst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(pkt_ready), 32'd1);
  endtask

  initial begin
    #12 nrst = 1'b1;
    @(posedge clk); #1;
    chk("init_ready", 32'(pkt_ready), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_en", 32'({en_MNI, en_NT, fwd_req}), 32'd0);
    chk("init_ftype", 32'(fPktType), 32'h7);
    chk("init_drop", 32'(drop_cnt), 32'd0);
    chk("init_hops", 32'(hops), 32'd0);

    send(PKT_HB,   16'd7,    16'd1,    16'h8000, 16'd1, 1'b0, 3, 2);
    send(PKT_HB,   16'd7,    16'd2,    16'h8000, 16'd1, 1'b0, 1, 0);
    send(PKT_CHE,  16'd32,   16'd4,    16'h0040, 16'd2, 1'b0, 0, 0);
    send(PKT_CHE,  MY,       16'd4,    16'h0040, 16'd2, 1'b0, 0, 0);
    send(PKT_INV,  16'd3,    16'd0,    16'h0100, 16'd5, 1'b0, 0, 0);
    send(PKT_INV,  16'd3,    16'd0,    16'h0100, 16'd5, 1'b1, 0, 0);
    send(PKT_DATA, 16'd14,   16'd6,    16'h0200, 16'd6, 1'b0, 2, 0);
    send(PKT_DATA, MY,       16'hFFFF, 16'h0200, 16'd6, 1'b0, 15, 1);
    send(PKT_HB,   16'd7,    16'd5,    16'h0300, 16'd7, 1'b0, -1, 0);
    send(3'b111,   16'd7,    16'd5,    16'h0300, 16'd7, 1'b0, 0, 0);
    send(PKT_CHTS, 16'd9,    16'd5,    16'h0300, 16'd7, 1'b0, 0, 0);
    send(PKT_CHTS, MY,       16'd5,    16'h0300, 16'd7, 1'b0, 0, 0);
    send(PKT_HB,   16'd7,    16'd8,    16'h0300, 16'd7, 1'b0, 16, 0);
    reset_mid();

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  t;
      logic [15:0] d, h;
      int          nd;
      t  = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 1) == 1) ? MY : 16'($urandom);
      h  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      nd = $urandom_range(0, 19);
      if (nd > 16) nd = -1;
      send(t, d, h, 16'($urandom), 16'($urandom), 1'($urandom),
           nd, $urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
